// File: rtl/ram_sp_sync_read_clr.sv
// Single-port RAM with registered read, selectable read-during-write behaviour
// and a clear sequencer that fills every word with INIT_VALUE after reset or on clr.
module ram_sp_sync_read_clr #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  write_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  addr_err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  accept;
    logic                  do_write;
    logic [DATA_WIDTH-1:0] rd_data;

    // User accesses only count in IDLE with no clear request; clr wins over both strobes.
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign accept   = !reset && (state == ST_IDLE) && !clr;
    assign do_write = accept && write_en && in_range;
    assign busy     = reset || (state == ST_CLEAR);

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            if (write_en && (RDW_MODE == 0)) begin
                rd_data = data_in;
            end else begin
                rd_data = mem[address];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end else begin
                        if (rd_en) begin
                            data_out <= rd_data;
                            rd_valid <= 1'b1;
                        end
                        addr_err <= (write_en || rd_en) && !in_range;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; contents are only defined by the clear sequencer.
    always_ff @(posedge clk) begin
        if (!reset && (state == ST_CLEAR)) begin
            mem[clr_ptr] <= INIT_VALUE;
        end else if (do_write) begin
            mem[address] <= data_in;
        end
    end

endmodule

// File: tb/tb_ram_sp_sync_read_clr.sv
// Bench for ram_sp_sync_read_clr: two instances (16-deep write-first, 12-deep read-first
// with INIT_VALUE FF) share one stimulus stream and are checked against a word-array model.
module tb_ram_sp_sync_read_clr;

    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] din;

    logic [7:0] dout [NI];
    logic       rv   [NI];
    logic       bsy  [NI];
    logic       aerr [NI];

    int n_err = 0;
    int n_chk = 0;

    int         p_depth [NI] = '{16, 12};
    int         p_rdw   [NI] = '{0, 1};
    logic [7:0] p_init  [NI] = '{8'h00, 8'hFF};

    logic [7:0] m_mem  [NI][16];
    int         m_left [NI];
    logic [7:0] m_dout [NI];
    logic       m_rv   [NI];
    logic       m_aerr [NI];
    logic       m_inr;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ram_sp_sync_read_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RDW_MODE(0), .INIT_VALUE(8'h00)
    ) dut_a (
        .clk(clk), .reset(reset), .clr(clr), .write_en(we), .rd_en(re),
        .address(addr), .data_in(din), .data_out(dout[0]), .rd_valid(rv[0]),
        .busy(bsy[0]), .addr_err(aerr[0])
    );

    ram_sp_sync_read_clr #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .RDW_MODE(1), .INIT_VALUE(8'hFF)
    ) dut_b (
        .clk(clk), .reset(reset), .clr(clr), .write_en(we), .rd_en(re),
        .address(addr), .data_in(din), .data_out(dout[1]), .rd_valid(rv[1]),
        .busy(bsy[1]), .addr_err(aerr[1])
    );

    // Reference: m_left counts remaining clear cycles; busy is expected whenever it is nonzero.
    initial begin
        for (int k = 0; k < NI; k++) begin
            m_left[k] = 0; m_dout[k] = 8'h00; m_rv[k] = 1'b0; m_aerr[k] = 1'b0;
            for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_left[k] = p_depth[k]; m_dout[k] = 8'h00; m_rv[k] = 1'b0; m_aerr[k] = 1'b0;
            end else if (m_left[k] > 0) begin
                m_mem[k][p_depth[k] - m_left[k]] = p_init[k];
                m_left[k] = m_left[k] - 1;
                m_rv[k] = 1'b0; m_aerr[k] = 1'b0;
            end else if (clr) begin
                m_left[k] = p_depth[k]; m_rv[k] = 1'b0; m_aerr[k] = 1'b0;
            end else begin
                m_inr     = (int'(addr) < p_depth[k]);
                m_aerr[k] = (we || re) && !m_inr;
                m_rv[k]   = re;
                if (re) begin
                    if (!m_inr) m_dout[k] = 8'h00;
                    else if (we && p_rdw[k] == 0) m_dout[k] = din;
                    else m_dout[k] = m_mem[k][addr];
                end
                if (we && m_inr) m_mem[k][addr] = din;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; we = 1'b0; re = 1'b0; addr = 4'h0; din = 8'h00;
    endtask

    task automatic test_reset();
        int n0, n1;
        n0 = 0; n1 = 0;
        reset = 1'b1;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (dout[k] !== 8'h00) begin n_err++; $display("FAIL reset[%0d] data_out got=%h exp=00", k, dout[k]); end
                if (rv[k] !== 1'b0) begin n_err++; $display("FAIL reset[%0d] rd_valid got=%b exp=0", k, rv[k]); end
                if (bsy[k] !== 1'b1) begin n_err++; $display("FAIL reset[%0d] busy got=%b exp=1", k, bsy[k]); end
                if (aerr[k] !== 1'b0) begin n_err++; $display("FAIL reset[%0d] addr_err got=%b exp=0", k, aerr[k]); end
            end
        end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 24; c++) begin
            if (bsy[0] === 1'b1) n0++;
            if (bsy[1] === 1'b1) n1++;
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 2;
                if (bsy[k] !== logic'(reset || m_left[k] > 0)) begin n_err++; $display("FAIL init[%0d] busy got=%b exp=%b", k, bsy[k], m_left[k] > 0); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL init[%0d] rd_valid got=%b exp=%b", k, rv[k], m_rv[k]); end
            end
        end
        n_chk += 2;
        if (n0 != 16) begin n_err++; $display("FAIL init_busy_len[0] got=%0d exp=16", n0); end
        if (n1 != 12) begin n_err++; $display("FAIL init_busy_len[1] got=%0d exp=12", n1); end
    endtask

    task automatic test_read_init();
        for (int a = 0; a < 17; a++) begin
            idle_inputs();
            if (a < 16) begin re = 1'b1; addr = 4'(a); end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL read_init[%0d] data_out got=%h exp=%h", k, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL read_init[%0d] rd_valid got=%b exp=%b", k, rv[k], m_rv[k]); end
                if (bsy[k] !== logic'(m_left[k] > 0)) begin n_err++; $display("FAIL read_init[%0d] busy got=%b", k, bsy[k]); end
                if (aerr[k] !== m_aerr[k]) begin n_err++; $display("FAIL read_init[%0d] addr_err got=%b exp=%b", k, aerr[k], m_aerr[k]); end
            end
            if (a < 16) begin
                n_chk += 2;
                if (dout[0] !== 8'h00) begin n_err++; $display("FAIL read_init_zero addr=%0d got=%h exp=00", a, dout[0]); end
                if (rv[0] !== 1'b1) begin n_err++; $display("FAIL read_init_valid addr=%0d got=%b exp=1", a, rv[0]); end
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] wdata;
        logic [7:0] exp_v;
        int hits;
        hits = 0;
        wdata = 8'h00;
        for (int c = 0; c < 32; c++) begin
            idle_inputs();
            addr = 4'(c >> 1);
            if ((c % 2) == 0) begin
                we = 1'b1; wdata = 8'($urandom_range(0, 255)); din = wdata;
            end else begin
                re = 1'b1; exp_q.push_back(wdata);
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL wr_rd[%0d] data_out got=%h exp=%h", k, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL wr_rd[%0d] rd_valid got=%b exp=%b", k, rv[k], m_rv[k]); end
                if (bsy[k] !== 1'b0) begin n_err++; $display("FAIL wr_rd[%0d] busy got=%b exp=0", k, bsy[k]); end
                if (aerr[k] !== m_aerr[k]) begin n_err++; $display("FAIL wr_rd[%0d] addr_err got=%b exp=%b", k, aerr[k], m_aerr[k]); end
            end
            if ((c % 2) == 1) begin
                exp_v = exp_q.pop_front();
                n_chk += 3;
                if (rv[0] !== 1'b1) begin n_err++; $display("FAIL wr_rd_sb valid addr=%0d got=%b exp=1", c >> 1, rv[0]); end
                if (aerr[0] !== 1'b0) begin n_err++; $display("FAIL wr_rd_sb addr_err addr=%0d got=%b exp=0", c >> 1, aerr[0]); end
                if (dout[0] !== exp_v) begin n_err++; $display("FAIL wr_rd_sb data addr=%0d got=%h exp=%h", c >> 1, dout[0], exp_v); end
                else hits++;
            end
        end
        n_chk++;
        if (hits != 16) begin n_err++; $display("FAIL wr_rd_hits got=%0d exp=16", hits); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            idle_inputs();
            we   = 1'($urandom_range(0, 1));
            re   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            din  = 8'($urandom_range(0, 255));
            clr  = ($urandom_range(0, 39) == 0);
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL random[%0d] c=%0d data_out got=%h exp=%h", k, c, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL random[%0d] c=%0d rd_valid got=%b exp=%b", k, c, rv[k], m_rv[k]); end
                if (bsy[k] !== logic'(m_left[k] > 0)) begin n_err++; $display("FAIL random[%0d] c=%0d busy got=%b", k, c, bsy[k]); end
                if (aerr[k] !== m_aerr[k]) begin n_err++; $display("FAIL random[%0d] c=%0d addr_err got=%b exp=%b", k, c, aerr[k], m_aerr[k]); end
            end
        end
        idle_inputs();
        for (int c = 0; c < 20; c++) tick();
    endtask

    task automatic test_rdw();
        for (int s = 0; s < 4; s++) begin
            idle_inputs();
            addr = 4'd5;
            case (s)
                0: begin we = 1'b1; din = 8'hAA; end
                1: begin we = 1'b1; re = 1'b1; din = 8'h55; end
                2: re = 1'b1;
                default: ;
            endcase
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 2;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL rdw[%0d] s=%0d data_out got=%h exp=%h", k, s, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL rdw[%0d] s=%0d rd_valid got=%b exp=%b", k, s, rv[k], m_rv[k]); end
            end
            if (s == 1) begin
                n_chk += 2;
                if (dout[0] !== 8'h55) begin n_err++; $display("FAIL rdw_write_first got=%h exp=55", dout[0]); end
                if (dout[1] !== 8'hAA) begin n_err++; $display("FAIL rdw_read_first got=%h exp=AA", dout[1]); end
            end
            if (s == 2) begin
                n_chk += 2;
                if (dout[0] !== 8'h55) begin n_err++; $display("FAIL rdw_after[0] got=%h exp=55", dout[0]); end
                if (dout[1] !== 8'h55) begin n_err++; $display("FAIL rdw_after[1] got=%h exp=55", dout[1]); end
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int s = 0; s < 15; s++) begin
            idle_inputs();
            if (s == 0) begin we = 1'b1; addr = 4'd13; din = 8'h3C; end
            else if (s == 1) begin re = 1'b1; addr = 4'd13; end
            else if (s < 14) begin re = 1'b1; addr = 4'(s - 2); end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 3;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL oor[%0d] s=%0d data_out got=%h exp=%h", k, s, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL oor[%0d] s=%0d rd_valid got=%b exp=%b", k, s, rv[k], m_rv[k]); end
                if (aerr[k] !== m_aerr[k]) begin n_err++; $display("FAIL oor[%0d] s=%0d addr_err got=%b exp=%b", k, s, aerr[k], m_aerr[k]); end
            end
            if (s == 0) begin
                n_chk += 2;
                if (aerr[1] !== 1'b1) begin n_err++; $display("FAIL oor_write_err got=%b exp=1", aerr[1]); end
                if (aerr[0] !== 1'b0) begin n_err++; $display("FAIL oor_write_ok got=%b exp=0", aerr[0]); end
            end
            if (s == 1) begin
                n_chk += 4;
                if (dout[1] !== 8'h00) begin n_err++; $display("FAIL oor_read_data got=%h exp=00", dout[1]); end
                if (rv[1] !== 1'b1) begin n_err++; $display("FAIL oor_read_valid got=%b exp=1", rv[1]); end
                if (aerr[1] !== 1'b1) begin n_err++; $display("FAIL oor_read_err got=%b exp=1", aerr[1]); end
                if (dout[0] !== 8'h3C) begin n_err++; $display("FAIL oor_inrange_data got=%h exp=3C", dout[0]); end
            end
        end
    endtask

    task automatic test_clr();
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            addr = 4'd3;
            if (c == 0) begin we = 1'b1; din = 8'h12; end
            else if (c == 1) begin clr = 1'b1; we = 1'b1; re = 1'b1; din = 8'h99; end
            else if (c <= 13) begin we = 1'b1; din = 8'h77; end
            else if (c == 18) re = 1'b1;
            tick();
            if (bsy[0] === 1'b1) n0++;
            if (bsy[1] === 1'b1) n1++;
            for (int k = 0; k < NI; k++) begin
                n_chk += 4;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL clr[%0d] c=%0d data_out got=%h exp=%h", k, c, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL clr[%0d] c=%0d rd_valid got=%b exp=%b", k, c, rv[k], m_rv[k]); end
                if (bsy[k] !== logic'(m_left[k] > 0)) begin n_err++; $display("FAIL clr[%0d] c=%0d busy got=%b", k, c, bsy[k]); end
                if (aerr[k] !== m_aerr[k]) begin n_err++; $display("FAIL clr[%0d] c=%0d addr_err got=%b exp=%b", k, c, aerr[k], m_aerr[k]); end
            end
        end
        n_chk += 4;
        if (n0 != 16) begin n_err++; $display("FAIL clr_busy_len[0] got=%0d exp=16", n0); end
        if (n1 != 12) begin n_err++; $display("FAIL clr_busy_len[1] got=%0d exp=12", n1); end
        if (dout[0] !== 8'h00) begin n_err++; $display("FAIL clr_readback[0] got=%h exp=00", dout[0]); end
        if (dout[1] !== 8'hFF) begin n_err++; $display("FAIL clr_readback[1] got=%h exp=FF", dout[1]); end
    endtask

    task automatic test_reset_mid_clear();
        int n0;
        n0 = 0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (c == 0) begin we = 1'b1; addr = 4'd0; din = 8'hAB; end
            else if (c == 1) begin we = 1'b1; addr = 4'd11; din = 8'hCD; end
            else if (c == 2) clr = 1'b1;
            else if (c == 7) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        #1;
        for (int c = 0; c < 34; c++) begin
            if (bsy[0] === 1'b1) n0++;
            idle_inputs();
            if (c >= 17 && c < 33) begin re = 1'b1; addr = 4'(c - 17); end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_chk += 3;
                if (dout[k] !== m_dout[k]) begin n_err++; $display("FAIL mid_rst[%0d] c=%0d data_out got=%h exp=%h", k, c, dout[k], m_dout[k]); end
                if (rv[k] !== m_rv[k]) begin n_err++; $display("FAIL mid_rst[%0d] c=%0d rd_valid got=%b exp=%b", k, c, rv[k], m_rv[k]); end
                if (bsy[k] !== logic'(m_left[k] > 0)) begin n_err++; $display("FAIL mid_rst[%0d] c=%0d busy got=%b", k, c, bsy[k]); end
            end
            if (c >= 17 && c < 33) begin
                n_chk++;
                if (dout[0] !== 8'h00) begin n_err++; $display("FAIL mid_rst_init addr=%0d got=%h exp=00", c - 17, dout[0]); end
            end
        end
        n_chk++;
        if (n0 != 16) begin n_err++; $display("FAIL mid_rst_busy_len got=%0d exp=16", n0); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read_init();
        test_write_read();
        test_rdw();
        test_out_of_range();
        test_random();
        test_clr();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
